// File: rtl/rf_wport_arb.sv
// Register-file write-port arbiter: WB stage vs. buffered long-latency results.
// WB wins by default; a starvation bound forces the LU FIFO head through.
module rf_wport_arb #(
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          ws_req_valid,
    input  logic                          ws_we,
    input  logic [4:0]                    ws_waddr,
    input  logic [31:0]                   ws_wdata,
    input  logic [31:0]                   ws_pc,
    output logic                          ws_gnt,
    input  logic                          lu_valid,
    output logic                          lu_ready,
    input  logic [4:0]                    lu_waddr,
    input  logic [31:0]                   lu_wdata,
    input  logic [31:0]                   lu_pc,
    output logic                          rf_we,
    output logic [4:0]                    rf_waddr,
    output logic [31:0]                   rf_wdata,
    output logic [31:0]                   debug_wb_pc,
    output logic [3:0]                    debug_wb_rf_wen,
    output logic [4:0]                    debug_wb_rf_wnum,
    output logic [31:0]                   debug_wb_rf_wdata,
    output logic [31:0]                   pend_mask,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    localparam logic [0:0] WB_FIRST = 1'b0;
    localparam logic [0:0] LU_FORCE = 1'b1;

    logic [4:0]            q_waddr [FIFO_DEPTH];
    logic [31:0]           q_wdata [FIFO_DEPTH];
    logic [31:0]           q_pc    [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] q_vld;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [0:0]    state;
    logic [SW-1:0] starve_cnt;

    logic fifo_ne;
    logic ws_wr;
    logic lu_turn;
    logic head_issue;
    logic lu_store;
    logic denied;
    logic starve_top;

    assign fifo_ne    = (count != '0);
    assign ws_wr      = ws_req_valid && ws_we && (ws_waddr != 5'd0);
    assign lu_turn    = (state == LU_FORCE) && fifo_ne;
    assign ws_gnt     = ws_req_valid && (!ws_wr || !lu_turn);
    assign head_issue = fifo_ne && (!ws_wr || lu_turn);
    assign lu_ready   = (count < CW'(FIFO_DEPTH));
    assign lu_store   = lu_valid && lu_ready && (lu_waddr != 5'd0);
    assign denied     = fifo_ne && !head_issue;
    assign starve_top = (starve_cnt == SW'(STARVE_MAX - 1));

    always_ff @(posedge clk) begin
        if (lu_store) begin
            q_waddr[wr_ptr] <= lu_waddr;
            q_wdata[wr_ptr] <= lu_wdata;
            q_pc[wr_ptr]    <= lu_pc;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q_vld  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (head_issue) begin
                q_vld[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + PW'(1);
            end
            if (lu_store) begin
                q_vld[wr_ptr] <= 1'b1;
                wr_ptr        <= wr_ptr + PW'(1);
            end
            unique case ({lu_store, head_issue})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= WB_FIRST;
            starve_cnt <= '0;
        end else begin
            unique case (state)
                WB_FIRST: if (denied && starve_top) state <= LU_FORCE;
                default:  if (head_issue) state <= WB_FIRST;
            endcase
            if (head_issue || !fifo_ne)
                starve_cnt <= '0;
            else if (!starve_top)
                starve_cnt <= starve_cnt + SW'(1);
        end
    end

    // A non-writing retirement still advances the trace PC.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rf_we       <= 1'b0;
            rf_waddr    <= 5'd0;
            rf_wdata    <= 32'd0;
            debug_wb_pc <= 32'd0;
        end else if (ws_gnt && ws_wr) begin
            rf_we       <= 1'b1;
            rf_waddr    <= ws_waddr;
            rf_wdata    <= ws_wdata;
            debug_wb_pc <= ws_pc;
        end else if (head_issue) begin
            rf_we       <= 1'b1;
            rf_waddr    <= q_waddr[rd_ptr];
            rf_wdata    <= q_wdata[rd_ptr];
            debug_wb_pc <= q_pc[rd_ptr];
        end else if (ws_gnt) begin
            rf_we       <= 1'b0;
            debug_wb_pc <= ws_pc;
        end else begin
            rf_we       <= 1'b0;
        end
    end

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (q_vld[i]) pend_mask[q_waddr[i]] = 1'b1;
        end
        if (rf_we) pend_mask[rf_waddr] = 1'b1;
        pend_mask[0] = 1'b0;
    end

    assign debug_wb_rf_wen   = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;
    assign fifo_count        = count;

endmodule

// File: tb/tb_rf_wport_arb.sv
// Bench for rf_wport_arb: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_rf_wport_arb;

    localparam int FD = 2;
    localparam int SM = 3;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        ws_req_valid, ws_we;
    logic [4:0]  ws_waddr;
    logic [31:0] ws_wdata, ws_pc;
    logic        ws_gnt;
    logic        lu_valid, lu_ready;
    logic [4:0]  lu_waddr;
    logic [31:0] lu_wdata, lu_pc;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, debug_wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata, pend_mask;
    logic [$clog2(FD):0] fifo_count;

    always #5 clk = ~clk;

    rf_wport_arb #(.FIFO_DEPTH(FD), .STARVE_MAX(SM)) dut (
        .clk(clk), .resetn(resetn),
        .ws_req_valid(ws_req_valid), .ws_we(ws_we), .ws_waddr(ws_waddr),
        .ws_wdata(ws_wdata), .ws_pc(ws_pc), .ws_gnt(ws_gnt),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_waddr(lu_waddr),
        .lu_wdata(lu_wdata), .lu_pc(lu_pc),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
        .debug_wb_rf_wnum(debug_wb_rf_wnum),
        .debug_wb_rf_wdata(debug_wb_rf_wdata),
        .pend_mask(pend_mask), .fifo_count(fifo_count)
    );

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        logic [31:0] pc;
    } ent_t;

    ent_t        q[$];
    int          starved;
    logic        m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata, m_pc;
    int          n_chk = 0;
    int          n_fail = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference: FIFO as a queue, starvation as a count of consecutive
    // denied cycles; forced once that count reaches the bound.
    initial begin
        forever begin
            logic        ne, forced, wr, turn, gnt, issue, rdy;
            logic [31:0] mask;
            ent_t        e;
            @(negedge clk);
            if (!resetn) begin
                q.delete();
                starved = 0;
                m_we = 0; m_waddr = 0; m_wdata = 0; m_pc = 0;
            end
            ne     = (q.size() > 0);
            forced = (starved >= SM);
            wr     = ws_req_valid && ws_we && (ws_waddr != 0);
            turn   = forced && ne;
            gnt    = ws_req_valid && (!wr || !turn);
            issue  = ne && (!wr || turn);
            rdy    = (q.size() < FD);
            mask   = 0;
            foreach (q[i]) mask = mask | (32'd1 << q[i].a);
            if (m_we) mask = mask | (32'd1 << m_waddr);
            mask[0] = 1'b0;
            chk("m_ws_gnt", ws_gnt, gnt);
            chk("m_lu_ready", lu_ready, rdy);
            chk("m_rf_we", rf_we, m_we);
            chk("m_rf_waddr", rf_waddr, m_waddr);
            chk("m_rf_wdata", rf_wdata, m_wdata);
            chk("m_dbg_pc", debug_wb_pc, m_pc);
            chk("m_dbg_wen", debug_wb_rf_wen, {4{m_we}});
            chk("m_dbg_wnum", debug_wb_rf_wnum, m_waddr);
            chk("m_dbg_wdata", debug_wb_rf_wdata, m_wdata);
            chk("m_pend_mask", pend_mask, mask);
            chk("m_fifo_count", fifo_count, q.size());
            if (resetn) begin
                if (gnt && wr) begin
                    m_we = 1; m_waddr = ws_waddr; m_wdata = ws_wdata; m_pc = ws_pc;
                end else if (issue) begin
                    e = q.pop_front();
                    m_we = 1; m_waddr = e.a; m_wdata = e.d; m_pc = e.pc;
                end else if (gnt) begin
                    m_we = 0; m_pc = ws_pc;
                end else begin
                    m_we = 0;
                end
                if (issue || !ne) starved = 0;
                else starved++;
                if (lu_valid && rdy && lu_waddr != 0) begin
                    e.a = lu_waddr; e.d = lu_wdata; e.pc = lu_pc;
                    q.push_back(e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic probe();
        @(negedge clk);
    endtask

    task automatic wb(input logic v, input logic we, input logic [4:0] a,
                      input logic [31:0] d, input logic [31:0] pc);
        ws_req_valid = v; ws_we = we; ws_waddr = a; ws_wdata = d; ws_pc = pc;
    endtask

    task automatic lu(input logic v, input logic [4:0] a,
                      input logic [31:0] d, input logic [31:0] pc);
        lu_valid = v; lu_waddr = a; lu_wdata = d; lu_pc = pc;
    endtask

    task automatic idle();
        wb(0, 0, 0, 0, 0);
        lu(0, 0, 0, 0);
    endtask

    initial begin
        idle();
        resetn = 0;
        repeat (3) step();
        probe();
        chk("rst_rf_we", rf_we, 0);
        chk("rst_pend", pend_mask, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_wen", debug_wb_rf_wen, 0);
        chk("rst_lu_ready", lu_ready, 1);
        step();
        resetn = 1;

        // WB-only write
        step();
        wb(1, 1, 5, 32'h1234, 32'h100);
        probe();
        chk("wb_gnt", ws_gnt, 1);
        step();
        idle();
        probe();
        chk("wb_rf_we", rf_we, 1);
        chk("wb_rf_waddr", rf_waddr, 5);
        chk("wb_rf_wdata", rf_wdata, 32'h1234);
        chk("wb_wen", debug_wb_rf_wen, 4'hf);
        chk("wb_pc", debug_wb_pc, 32'h100);
        chk("wb_pend", pend_mask, 32'h20);

        // Starvation bound
        step();
        wb(1, 1, 5, 32'h55, 32'h200);
        lu(1, 8, 32'hAA, 32'h300);
        probe();
        chk("st_gnt_push", ws_gnt, 1);
        step();
        lu(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            probe();
            chk("st_gnt_wb", ws_gnt, 1);
            step();
        end
        probe();
        chk("st_gnt_denied", ws_gnt, 0);
        step();
        probe();
        chk("st_rf_waddr", rf_waddr, 8);
        chk("st_rf_wdata", rf_wdata, 32'hAA);
        chk("st_pc", debug_wb_pc, 32'h300);
        chk("st_gnt_back", ws_gnt, 1);
        step();
        idle();

        // Idle-port drain and full handling
        wb(1, 1, 3, 32'h33, 32'h400);
        lu(1, 3, 32'hC3, 32'h500);
        probe();
        step();
        lu(1, 4, 32'hC4, 32'h504);
        probe();
        chk("dr_ready1", lu_ready, 1);
        chk("dr_count1", fifo_count, 1);
        step();
        lu(0, 0, 0, 0);
        wb(1, 0, 0, 0, 32'h600);
        probe();
        chk("dr_gnt", ws_gnt, 1);
        chk("dr_pend0", pend_mask, 32'h18);
        chk("dr_count2", fifo_count, 2);
        chk("dr_full", lu_ready, 0);
        step();
        probe();
        chk("dr_r3", rf_waddr, 3);
        chk("dr_r3d", rf_wdata, 32'hC3);
        chk("dr_count3", fifo_count, 1);
        chk("dr_ready_after_pop", lu_ready, 1);
        chk("dr_pend1", pend_mask, 32'h18);
        step();
        probe();
        chk("dr_r4", rf_waddr, 4);
        chk("dr_pend2", pend_mask, 32'h10);
        chk("dr_count4", fifo_count, 0);
        step();
        idle();
        probe();
        chk("dr_we_off", rf_we, 0);
        chk("dr_pend3", pend_mask, 0);
        chk("dr_pc", debug_wb_pc, 32'h600);

        // Push+pop same cycle, then register zero
        step();
        wb(1, 1, 5, 32'h77, 32'h700);
        lu(1, 6, 32'hD6, 32'h700);
        probe();
        step();
        wb(1, 0, 0, 0, 32'h710);
        lu(1, 7, 32'hD7, 32'h720);
        probe();
        chk("pp_count_before", fifo_count, 1);
        step();
        wb(1, 1, 0, 32'hBAD, 32'h730);
        lu(1, 0, 32'hEE, 32'h740);
        probe();
        chk("pp_count_kept", fifo_count, 1);
        chk("pp_r6", rf_waddr, 6);
        chk("z_gnt", ws_gnt, 1);
        step();
        lu(0, 0, 0, 0);
        probe();
        chk("z_head_r7", rf_waddr, 7);
        chk("z_head_we", rf_we, 1);
        chk("z_count", fifo_count, 0);
        chk("z_pend", pend_mask, 32'h80);
        step();
        probe();
        chk("z_no_write", rf_we, 0);
        chk("z_pc", debug_wb_pc, 32'h730);
        step();
        idle();

        // Reset mid-queue
        wb(1, 1, 5, 32'h99, 32'h800);
        lu(1, 9, 32'hE9, 32'h900);
        step();
        lu(1, 10, 32'hEA, 32'h904);
        step();
        lu(0, 0, 0, 0);
        probe();
        chk("rq_count", fifo_count, 2);
        chk("rq_ready", lu_ready, 0);
        step();
        resetn = 0;
        #1;
        chk("rq_count0", fifo_count, 0);
        chk("rq_pend0", pend_mask, 0);
        chk("rq_we0", rf_we, 0);
        idle();
        step();
        resetn = 1;
        probe();
        chk("rq_ready1", lu_ready, 1);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            step();
            resetn = ($urandom_range(0, 299) != 0);
            wb($urandom_range(0, 9) < 7, $urandom_range(0, 1),
               ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
               $urandom, $urandom);
            lu($urandom_range(0, 1),
               ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
               $urandom, $urandom);
        end
        step();
        resetn = 1;
        idle();
        repeat (4) step();
        probe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_wport_arb.md
Name: rf_wport_arb

Overview:
Arbiter and sequencer for the single general-register-file write port. It is shared between the in-order WB stage and an out-of-band long-latency unit (LU), such as the multiply/divide writeback. LU results are buffered in a small FIFO. WB has priority, with a starvation bound that forces the LU through. The winning write is registered toward the regfile and the trace-debug interface, and a pending-destination mask goes to ID for hazard checks.

Parameters:
FIFO_DEPTH, 2, LU buffer entries; power of 2, minimum 2.
STARVE_MAX, 3, consecutive cycles a non-empty FIFO may be denied before it gets forced priority; minimum 1.

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous, active-low reset
ws_req_valid  in  1  WB holds a valid instruction this cycle
ws_we  in  1  WB instruction writes a GPR
ws_waddr  in  5  WB destination register
ws_wdata  in  32  WB write data
ws_pc  in  32  WB instruction PC
ws_gnt  out  1  WB may retire this cycle; used as WB ready_go
lu_valid  in  1  LU result offered
lu_ready  out  1  FIFO can accept the LU result
lu_waddr  in  5  LU destination register
lu_wdata  in  32  LU result
lu_pc  in  32  PC of the originating instruction
rf_we  out  1  registered regfile write enable
rf_waddr  out  5  registered write address
rf_wdata  out  32  registered write data
debug_wb_pc  out  32  trace PC
debug_wb_rf_wen  out  4  trace write enable, equal to {4{rf_we}}
debug_wb_rf_wnum  out  5  trace register number
debug_wb_rf_wdata  out  32  trace write data
pend_mask  out  32  bit i set means a write to GPR i is queued or in the output register
fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (resetn low, asynchronous):
  - FIFO empty; starve_cnt = 0; state = WB_FIRST.
  - rf_we, rf_waddr, rf_wdata = 0; all debug outputs = 0.
  - pend_mask = 0; fifo_count = 0.
  - A reset asserted mid-operation discards all queued LU results.
- Derived terms:
  - ws_wr = ws_req_valid && ws_we && (ws_waddr != 0).
  - lu_turn = (state == LU_FORCE) && FIFO non-empty.
- Grant (combinational):
  - ws_gnt = ws_req_valid && (!ws_wr || !lu_turn).
  - head_issue = FIFO non-empty && (!ws_wr || lu_turn).
  - WB and LU writes never issue in the same cycle. A non-writing WB retirement and an LU issue may coincide.
- FSM, two states:
  - WB_FIRST -> LU_FORCE when the FIFO is non-empty, head is not issued, and starve_cnt == STARVE_MAX-1.
  - LU_FORCE -> WB_FIRST on head_issue.
  - starve_cnt increments, saturating, on each denied cycle with the FIFO non-empty. It clears on head_issue or when the FIFO is empty.
- LU handshake:
  - lu_ready = (fifo_count < FIFO_DEPTH), derived from registered occupancy only; no same-cycle pop bypass.
  - Push on lu_valid && lu_ready. An entry with lu_waddr == 0 is accepted but not stored.
  - Push and pop in the same cycle leave occupancy unchanged. Pointers wrap modulo FIFO_DEPTH.
- Output register (1-cycle latency from grant to write):
  - On a WB write grant: rf_we <= 1, and address/data/PC are taken from WB.
  - On head_issue: rf_we <= 1, with the head entry's fields; the FIFO pops.
  - On a non-writing WB grant with no head_issue: rf_we <= 0, debug_wb_pc <= ws_pc.
  - When nothing is granted: rf_we <= 0; address, data and PC hold.
  - Debug outputs mirror the output register. debug_wb_rf_wnum/wdata equal rf_waddr/rf_wdata.
- pend_mask:
  - Combinational OR of the one-hot destinations of all valid FIFO entries and of rf_waddr when rf_we = 1.
  - Bit 0 is always 0.
- Ordering: WAW ordering between WB and LU for the same register is the issue logic's responsibility; this block does not reorder within the FIFO.

Test Plan:
- Reset mid-queue: fill FIFO with 2 LU results, assert resetn=0 -> fifo_count=0, pend_mask=0, rf_we=0 immediately; after release, lu_ready=1.
- WB-only stream: ws_req_valid=1, ws_we=1, ws_waddr=5, ws_wdata=0x1234 -> ws_gnt=1; next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234, debug_wb_rf_wen=4'hf.
- Starvation: LU pushes waddr=8 while WB writes every cycle, STARVE_MAX=3 -> WB granted 3 cycles, then ws_gnt=0 for one cycle and rf_waddr=8 the cycle after; state returns to WB_FIRST.
- Idle-port drain: FIFO holds writes to r3 and r4, WB valid with ws_we=0 -> ws_gnt=1 and r3 written the next cycle, r4 the cycle after; pend_mask goes 0x18 -> 0x10 -> 0.
- Full/simultaneous: FIFO full -> lu_ready=0; pop on cycle N -> lu_ready=1 on N+1. Push+pop in one cycle keeps fifo_count constant.
- Register zero: ws_waddr=0, ws_we=1 -> no port use, rf_we=0, LU head issues that cycle. lu_waddr=0 accepted, fifo_count unchanged.
